led_event_blinker: RTL
======================

Name: led_event_blinker

Overview:
- Output-side counterpart to the button input path.
- Takes 1-cycle event pulses, e.g. a debounced press pulse or any internal strobe.
- Turns each event into one human-visible LED blink with fixed ON time and minimum OFF gap.
- Events that arrive during a blink are queued in a saturating pending counter, so no press is lost visually up to the queue depth.

Parameters:
- ON_CYCLES, 1200000, LED on-time per blink in clk cycles (100 ms at 12 MHz); must be >= 1.
- OFF_CYCLES, 1200000, mandatory LED off-gap after each blink in clk cycles; must be >= 1.
- MAX_PENDING, 7, saturation value of the pending-event counter; must be >= 1.
- PEND_W, 3, width of pending port; must satisfy 2^PEND_W - 1 >= MAX_PENDING.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- ev_pulse  input  1  event strobe; each high cycle is one event.
- clr_ovf  input  1  synchronous clear of overflow flag.
- led  output  1  LED drive, active-high, registered.
- busy  output  1  high while state is ON or GAP.
- pending  output  PEND_W  queued events not yet started.
- overflow  output  1  sticky: an event was dropped.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, timer=0, led=0, busy=0, pending=0, overflow=0. Takes effect immediately, including mid-blink.
- Single timer, width clog2(max(ON_CYCLES, OFF_CYCLES)+1). Loaded on each state entry, counts down.
- FSM states: IDLE, ON, GAP. All outputs are registered or decoded from registered state (no combinational path from ev_pulse).
  - led = (state==ON).
  - busy = (state!=IDLE).
- IDLE:
  - ev_pulse=1 and pending=0 -> ON next cycle; pending unchanged (event consumed directly).
  - pending>0 -> ON next cycle; pending decrements. If ev_pulse is also high, pending is unchanged (+1 and -1 cancel).
  - Otherwise stay in IDLE.
- ON: lasts exactly ON_CYCLES cycles, then -> GAP.
- GAP: lasts exactly OFF_CYCLES cycles. On its last cycle:
  - pending>0 or ev_pulse=1 -> ON, with the same pending update rules as IDLE.
  - Otherwise -> IDLE.
- Timing:
  - ev_pulse at cycle N from idle gives led=1 for cycles N+1 .. N+ON_CYCLES.
  - Blink period is ON_CYCLES+OFF_CYCLES when back-to-back.
- Pending counter, when no blink starts that cycle:
  - ev_pulse=1 increments pending, saturating at MAX_PENDING.
  - If pending==MAX_PENDING, the event is dropped and overflow is set at the next edge.
  - Events are never dropped on a cycle where a blink starts (the decrement frees a slot).
- Overflow: sticky. clr_ovf=1 clears it next cycle. Simultaneous set and clear: set wins.
- ev_pulse held high for K cycles counts as K events.

Test Plan (ON_CYCLES=4, OFF_CYCLES=3, MAX_PENDING=3, PEND_W=2):
- Reset: drive rst=0 during ON state -> led=0, busy=0, pending=0, overflow=0 before the next clk edge. After release with no events, all outputs stay 0.
- Single event: ev_pulse at cycle 10 -> led=1 cycles 11-14; led=0 cycles 15-17 with busy=1; busy=0 from cycle 18; pending stays 0 throughout.
- Burst of 3: ev_pulse at cycles 10, 11, 12 -> pending=1 at 12 and 2 at 13. Blinks at led cycles 11-14, 18-21, 25-28. Pending drops to 1 at 18 and 0 at 25. busy=0 from 32.
- Overflow: ev_pulse cycles 10-14 (5 events) -> pending reaches 3 at 14; 5th event dropped; overflow=1 at 15; exactly 4 blinks total. clr_ovf at 20 -> overflow=0 at 21. clr_ovf and a dropped event in the same cycle -> overflow stays 1.
- Simultaneous: pending=1 and ev_pulse on the last GAP cycle -> ON next cycle, pending remains 1, then one further blink.
- Gap enforcement: ev_pulse at cycle 16 (mid-GAP, single prior blink) -> pending=1 at 17; next led rise at cycle 18, never earlier.

Source files
------------

// File: rtl/led_event_blinker.sv
// Turns 1-cycle event strobes into visible LED blinks with a fixed on-time
// and a minimum off-gap, queueing events that arrive during a blink.
module led_event_blinker #(
   parameter int ON_CYCLES   = 1200000,
   parameter int OFF_CYCLES  = 1200000,
   parameter int MAX_PENDING = 7,
   parameter int PEND_W      = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ev_pulse,
   input  logic              clr_ovf,
   output logic              led,
   output logic              busy,
   output logic [PEND_W-1:0] pending,
   output logic              overflow
);

   localparam int MAXC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int TW   = $clog2(MAXC + 1);

   localparam logic [TW-1:0]     ON_LD  = TW'(ON_CYCLES - 1);
   localparam logic [TW-1:0]     OFF_LD = TW'(OFF_CYCLES - 1);
   localparam logic [PEND_W-1:0] PMAX   = PEND_W'(MAX_PENDING);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ON,
      S_GAP
   } state_e;

   state_e            state_q, state_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic [PEND_W-1:0] pend_q, pend_d;
   logic              ovf_q, ovf_d;
   logic              want;
   logic              start;
   logic              drop;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         pend_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      pend_d  = pend_q;
      start   = 1'b0;
      drop    = 1'b0;
      want    = ev_pulse || (pend_q != '0);

      unique case (state_q)
         S_IDLE: begin
            start = want;
         end
         S_ON: begin
            if (timer_q == '0) begin
               state_d = S_GAP;
               timer_d = OFF_LD;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         S_GAP: begin
            if (timer_q == '0) begin
               if (want) start = 1'b1;
               else      state_d = S_IDLE;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            timer_d = '0;
         end
      endcase

      // a starting blink consumes either this cycle's event or one queued
      if (start) begin
         state_d = S_ON;
         timer_d = ON_LD;
         if (!ev_pulse && pend_q != '0) pend_d = pend_q - 1'b1;
      end else if (ev_pulse) begin
         if (pend_q >= PMAX) drop = 1'b1;
         else                pend_d = pend_q + 1'b1;
      end

      ovf_d = drop | (ovf_q & ~clr_ovf);
   end

   assign led      = (state_q == S_ON);
   assign busy     = (state_q != S_IDLE);
   assign pending  = pend_q;
   assign overflow = ovf_q;

endmodule
